// File: rtl/demux8x16_pkg.sv
// Shared constants and channel-index type for the 8-channel, 16-bit sequential demux.
// Optional overrun detection is enabled by defining DEMUX8X16_OVR_EN.
package demux8x16_pkg;

   localparam int unsigned NCH = 8;
   localparam int unsigned DW  = 16;
   localparam int unsigned CW  = 3;

   typedef logic [CW-1:0] ch_t;

   localparam ch_t LAST_CH = ch_t'(NCH - 1);

endpackage

// File: rtl/demux_chan.sv
// One demux channel: held data register, data-valid flag and sticky overrun flag.
// Overrun logic exists only when DEMUX8X16_OVR_EN is defined; otherwise ovr_o is tied to 0.
module demux_chan
   import demux8x16_pkg::*;
(
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          we_i,
   input  logic          ack_i,
   input  logic [DW-1:0] d_i,
   output logic [DW-1:0] y_o,
   output logic          yv_o,
   output logic          ovr_o
);

   logic [DW-1:0] y_q, y_d;
   logic          yv_q, yv_d;

   // A write wins over a same-cycle ACK, so the fresh word stays valid.
   always_comb begin
      y_d  = y_q;
      yv_d = yv_q;
      if (we_i) begin
         y_d  = d_i;
         yv_d = 1'b1;
      end else if (ack_i) begin
         yv_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         y_q  <= '0;
         yv_q <= 1'b0;
      end else begin
         y_q  <= y_d;
         yv_q <= yv_d;
      end
   end

   assign y_o  = y_q;
   assign yv_o = yv_q;

`ifdef DEMUX8X16_OVR_EN
   logic ovr_q, ovr_d;

   // Overwriting an unconsumed word is an overrun; the flag is sticky until reset.
   always_comb begin
      ovr_d = ovr_q | (we_i & yv_q & ~ack_i);
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         ovr_q <= 1'b0;
      end else begin
         ovr_q <= ovr_d;
      end
   end

   assign ovr_o = ovr_q;
`else
   assign ovr_o = 1'b0;
`endif

endmodule

// File: rtl/demux8x16_seq.sv
// Sequential 1-to-8 demux of 16-bit words with auto channel counter, frame pulse and per-channel hold.
// Define DEMUX8X16_OVR_EN to enable sticky per-channel overrun detection on OVR.
module demux8x16_seq
   import demux8x16_pkg::*;
(
   input  logic           CLK,
   input  logic           RSTN,
   input  logic [DW-1:0]  D,
   input  logic           DV,
   input  logic [CW-1:0]  S,
   input  logic           AUTO,
   input  logic           SYNC,
   output logic [DW-1:0]  Y0,
   output logic [DW-1:0]  Y1,
   output logic [DW-1:0]  Y2,
   output logic [DW-1:0]  Y3,
   output logic [DW-1:0]  Y4,
   output logic [DW-1:0]  Y5,
   output logic [DW-1:0]  Y6,
   output logic [DW-1:0]  Y7,
   output logic [NCH-1:0] YV,
   input  logic [NCH-1:0] ACK,
   output logic [CW-1:0]  CH,
   output logic           FRM,
   output logic [NCH-1:0] OVR
);

   ch_t            cnt_q, cnt_d;
   ch_t            tgt;
   logic           frm_q, frm_d;
   logic [NCH-1:0] we;
   logic [DW-1:0]  y [NCH];

   // SYNC in auto mode redirects the current word to channel 0 and restarts the count after it.
   always_comb begin
      tgt = AUTO ? (SYNC ? '0 : cnt_q) : ch_t'(S);

      we = '0;
      if (DV) begin
         we[tgt] = 1'b1;
      end

      cnt_d = cnt_q;
      if (SYNC) begin
         cnt_d = (DV && AUTO) ? ch_t'(1) : '0;
      end else if (DV && AUTO) begin
         cnt_d = cnt_q + ch_t'(1);
      end

      frm_d = DV && AUTO && (tgt == LAST_CH);
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         cnt_q <= '0;
         frm_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         frm_q <= frm_d;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      demux_chan u_chan (
         .clk_i  (CLK),
         .rstn_i (RSTN),
         .we_i   (we[i]),
         .ack_i  (ACK[i]),
         .d_i    (D),
         .y_o    (y[i]),
         .yv_o   (YV[i]),
         .ovr_o  (OVR[i])
      );
   end

   assign Y0  = y[0];
   assign Y1  = y[1];
   assign Y2  = y[2];
   assign Y3  = y[3];
   assign Y4  = y[4];
   assign Y5  = y[5];
   assign Y6  = y[6];
   assign Y7  = y[7];
   assign CH  = cnt_q;
   assign FRM = frm_q;

endmodule

// File: tb/tb_demux8x16_seq.sv
// Scoreboard bench for demux8x16_seq: directed cycles push hand-derived expected outputs, a monitor compares.
// Expected OVR follows DEMUX8X16_OVR_EN the same way the design does.
module tb_demux8x16_seq;

   typedef struct packed {
      logic [7:0][15:0] y;
      logic [7:0]       yv;
      logic [2:0]       ch;
      logic             frm;
      logic [7:0]       ovr;
   } snap_t;

`ifdef DEMUX8X16_OVR_EN
   localparam bit OVR_ON = 1'b1;
`else
   localparam bit OVR_ON = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RSTN, DV, AUTO, SYNC;
   logic [15:0] D;
   logic [2:0]  S;
   logic [7:0]  ACK;
   logic [15:0] Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
   logic [7:0]  YV, OVR;
   logic [2:0]  CH;
   logic        FRM;

   demux8x16_seq dut (
      .CLK (CLK), .RSTN (RSTN), .D (D), .DV (DV), .S (S), .AUTO (AUTO), .SYNC (SYNC),
      .Y0 (Y0), .Y1 (Y1), .Y2 (Y2), .Y3 (Y3), .Y4 (Y4), .Y5 (Y5), .Y6 (Y6), .Y7 (Y7),
      .YV (YV), .ACK (ACK), .CH (CH), .FRM (FRM), .OVR (OVR)
   );

   always #5 CLK = ~CLK;

   snap_t q[$];
   snap_t ex;
   int    total = 0;
   int    bad   = 0;
   bit    stim_done = 1'b0;

   task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s[%0d] t=%0t got=%h want=%h", name, idx, $time, act, want);
      end
   endtask

   initial begin : monitor
      snap_t e;
      logic [7:0][15:0] ay;
      forever begin
         @(negedge CLK);
         if (q.size() > 0) begin
            e  = q.pop_front();
            ay = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};
            for (int k = 0; k < 8; k++) chk("Y", k, ay[k], e.y[k]);
            chk("YV", 0, {8'h00, YV}, {8'h00, e.yv});
            chk("CH", 0, {13'h0, CH}, {13'h0, e.ch});
            chk("FRM", 0, {15'h0, FRM}, {15'h0, e.frm});
            chk("OVR", 0, {8'h00, OVR}, {8'h00, e.ovr});
         end
      end
   end

   task automatic drive(input logic rstn, input logic auto_m, input logic dv, input logic [2:0] s,
                        input logic [15:0] d, input logic sync, input logic [7:0] ack);
      RSTN = rstn; AUTO = auto_m; DV = dv; S = s; D = d; SYNC = sync; ACK = ack;
   endtask

   // Push the outputs expected after the coming edge, then move inputs off the edge.
   task automatic tick();
      @(posedge CLK);
      q.push_back(ex);
      #1;
   endtask

   task automatic set_ovr(input logic [7:0] m);
      if (OVR_ON) ex.ovr = ex.ovr | m;
   endtask

   task automatic clear_all();
      ex = '0;
   endtask

   initial begin : stim
      clear_all();
      drive(1'b0, 1'b1, 1'b1, 3'd0, 16'hFFFF, 1'b0, 8'h00);
      tick(); tick();

      // Auto-mode frame of eight words.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, 1'b1, 3'd0, 16'h1000 + 16'(i), 1'b0, 8'h00);
         ex.y[i]   = 16'h1000 + 16'(i);
         ex.yv[i]  = 1'b1;
         ex.ch     = 3'(i + 1);
         ex.frm    = (i == 7);
         tick();
      end
      drive(1'b1, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 8'h00);
      ex.frm = 1'b0;
      tick();

      // Consume everything, then explicit select to channel 5 and ACK one cycle later.
      drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 8'hFF);
      ex.yv = 8'h00;
      tick();
      drive(1'b1, 1'b0, 1'b1, 3'd5, 16'hBEEF, 1'b0, 8'h00);
      ex.y[5] = 16'hBEEF; ex.yv = 8'h20;
      tick();
      drive(1'b1, 1'b0, 1'b0, 3'd5, 16'h0, 1'b0, 8'h20);
      ex.yv = 8'h00;
      tick();
      // Explicit write to channel 7 must not pulse FRM.
      drive(1'b1, 1'b0, 1'b1, 3'd7, 16'h7007, 1'b0, 8'h00);
      ex.y[7] = 16'h7007; ex.yv = 8'h80;
      tick();
      drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 8'hFF);
      ex.yv = 8'h00;
      tick();

      // Bring CNT to 3, drain, then SYNC with data and SYNC alone.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b1, 3'd0, 16'h2000 + 16'(i), 1'b0, 8'h00);
         ex.y[i] = 16'h2000 + 16'(i); ex.yv[i] = 1'b1; ex.ch = 3'(i + 1);
         tick();
      end
      drive(1'b1, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 8'hFF);
      ex.yv = 8'h00;
      tick();
      drive(1'b1, 1'b1, 1'b1, 3'd6, 16'h0A0A, 1'b1, 8'h00);
      ex.y[0] = 16'h0A0A; ex.yv = 8'h01; ex.ch = 3'd1;
      tick();
      drive(1'b1, 1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 8'h00);
      ex.ch = 3'd0;
      tick();
      drive(1'b1, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 8'hFF);
      ex.yv = 8'h00;
      tick();

      // Overrun: two writes to channel 2 without ACK, then a write+ACK on channel 3.
      drive(1'b1, 1'b0, 1'b1, 3'd2, 16'h1111, 1'b0, 8'h00);
      ex.y[2] = 16'h1111; ex.yv = 8'h04;
      tick();
      drive(1'b1, 1'b0, 1'b1, 3'd2, 16'h2222, 1'b0, 8'h00);
      ex.y[2] = 16'h2222; set_ovr(8'h04);
      tick();
      drive(1'b1, 1'b0, 1'b0, 3'd2, 16'h0, 1'b0, 8'h04);
      ex.yv = 8'h00;
      tick();
      drive(1'b1, 1'b0, 1'b1, 3'd3, 16'h4444, 1'b0, 8'h00);
      ex.y[3] = 16'h4444; ex.yv = 8'h08;
      tick();
      drive(1'b1, 1'b0, 1'b1, 3'd3, 16'h5555, 1'b0, 8'h08);
      ex.y[3] = 16'h5555;
      tick();
      drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 8'hFF);
      ex.yv = 8'h00;
      tick();

      // Mid-frame reset at CNT=6 with a word presented, then first word after reset.
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b1, 1'b1, 3'd0, 16'h6000 + 16'(i), 1'b0, 8'h00);
         ex.y[i] = 16'h6000 + 16'(i); ex.yv[i] = 1'b1; ex.ch = 3'(i + 1);
         tick();
      end
      drive(1'b0, 1'b1, 1'b1, 3'd0, 16'hDEAD, 1'b1, 8'hFF);
      clear_all();
      tick();
      drive(1'b1, 1'b1, 1'b1, 3'd4, 16'h7777, 1'b0, 8'h00);
      ex.y[0] = 16'h7777; ex.yv = 8'h01; ex.ch = 3'd1;
      tick();
      drive(1'b1, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 8'h00);
      tick();

      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge CLK);
      #1;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d want=0", q.size());
      end
      stim_done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
